// File: rtl/fx_rob_name_alloc_pkg.sv
// Shared sizing and types for the fixed-point ROB name allocator.
// Pointers carry one extra wrap bit above the entry index.
package fx_rob_name_alloc_pkg;

  localparam int ROB_ENTRY_WIDTH    = 7;
  localparam int ROB_ENTRIES        = 1 << ROB_ENTRY_WIDTH;
  localparam int MAX_BUNDLE         = 4;
  localparam int NUM_COMPLETE_PORTS = 2;

  typedef struct packed {
    logic                       wrap;
    logic [ROB_ENTRY_WIDTH-1:0] idx;
  } rob_ptr_t;

endpackage

// File: rtl/fx_rob_name_alloc_if.sv
// Bundle of allocation, completion and retire signals between the rename
// stage (master) and the ROB name allocator (slave).
interface fx_rob_name_alloc_if #(
  parameter int W = 7,
  parameter int P = 2
);
  logic         enable_i;
  logic         flush_i;
  logic         allocValid_i;
  logic [1:0]   numInst_i;
  logic         stall_o;
  logic         allocValid_o;
  logic [W-1:0] allocName1_o;
  logic [W-1:0] allocName2_o;
  logic [W-1:0] allocName3_o;
  logic [W-1:0] allocName4_o;
  logic         completeValid_i [P];
  logic [W-1:0] completeName_i  [P];
  logic         clearName1_o;
  logic         clearName2_o;
  logic         clearName3_o;
  logic         clearName4_o;
  logic [W-1:0] ROBName1_o;
  logic [W-1:0] ROBName2_o;
  logic [W-1:0] ROBName3_o;
  logic [W-1:0] ROBName4_o;
  logic [W:0]   freeCount_o;

  modport master (
    output enable_i, flush_i, allocValid_i, numInst_i, completeValid_i, completeName_i,
    input  stall_o, allocValid_o, allocName1_o, allocName2_o, allocName3_o, allocName4_o,
    input  clearName1_o, clearName2_o, clearName3_o, clearName4_o,
    input  ROBName1_o, ROBName2_o, ROBName3_o, ROBName4_o, freeCount_o
  );

  modport slave (
    input  enable_i, flush_i, allocValid_i, numInst_i, completeValid_i, completeName_i,
    output stall_o, allocValid_o, allocName1_o, allocName2_o, allocName3_o, allocName4_o,
    output clearName1_o, clearName2_o, clearName3_o, clearName4_o,
    output ROBName1_o, ROBName2_o, ROBName3_o, ROBName4_o, freeCount_o
  );
endinterface

// File: rtl/fx_rob_name_alloc_retire_scan.sv
// Counts consecutive ready (valid && done) entries starting at the ROB head.
// Slot 0 is the head; the count stops at the first slot that is not ready.
module fx_rob_name_alloc_retire_scan
  import fx_rob_name_alloc_pkg::*;
(
  input  logic [MAX_BUNDLE-1:0] ready,
  output logic [2:0]            count
);
  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int i = 0; i < MAX_BUNDLE; i++) begin
      if (run && ready[i]) count = count + 3'd1;
      else                 run   = 1'b0;
    end
  end
endmodule

// File: rtl/fx_rob_name_alloc.sv
// Circular ROB name allocator with in-order retire of up to four completed
// head entries per cycle; retire results feed the RAT clear inputs.
module fx_rob_name_alloc
  import fx_rob_name_alloc_pkg::*;
#(
  parameter int ROBEntryWidth    = ROB_ENTRY_WIDTH,
  parameter int numCompletePorts = NUM_COMPLETE_PORTS
) (
  input  logic              clock_i,
  input  logic              reset_i,
  fx_rob_name_alloc_if.slave bus
);
  localparam int         W       = ROBEntryWidth;
  localparam int         N       = 1 << W;
  localparam logic [W:0] ENTRIES = (W+1)'(N);

  logic [W:0]            head_reg, head_next, tail_reg, tail_next;
  logic [N-1:0]          valid_reg, valid_next, done_reg, done_next;
  logic [W:0]            free_count, req_count;
  logic                  alloc_fire, retire_fire;
  logic [2:0]            retire_count;
  logic [MAX_BUNDLE-1:0] head_ready;
  logic [W-1:0]          head_name [MAX_BUNDLE];
  logic [W-1:0]          tail_name [MAX_BUNDLE];

  logic                  alloc_valid_reg;
  logic [W-1:0]          alloc_name_reg [MAX_BUNDLE];
  logic [W-1:0]          alloc_name_next [MAX_BUNDLE];
  logic [MAX_BUNDLE-1:0] clear_reg, clear_next;
  logic [W-1:0]          rob_name_reg [MAX_BUNDLE];
  logic [W-1:0]          rob_name_next [MAX_BUNDLE];

  // Stall and free count deliberately use the pre-retire head.
  assign free_count  = ENTRIES - (tail_reg - head_reg);
  assign req_count   = (W+1)'(bus.numInst_i) + (W+1)'(1);
  assign bus.stall_o = bus.allocValid_i && (free_count < req_count);
  assign alloc_fire  = bus.enable_i && bus.allocValid_i && !bus.stall_o && !bus.flush_i;
  assign retire_fire = bus.enable_i && !bus.flush_i;

  generate
    for (genvar gi = 0; gi < MAX_BUNDLE; gi++) begin : g_slot
      assign head_name[gi]       = head_reg[W-1:0] + W'(gi);
      assign tail_name[gi]       = tail_reg[W-1:0] + W'(gi);
      assign head_ready[gi]      = valid_reg[head_name[gi]] && done_reg[head_name[gi]];
      assign alloc_name_next[gi] = (alloc_fire && (gi <= int'(bus.numInst_i))) ? tail_name[gi] : '0;
      assign clear_next[gi]      = retire_fire && (3'(gi) < retire_count);
      assign rob_name_next[gi]   = clear_next[gi] ? head_name[gi] : '0;
    end
  endgenerate

  fx_rob_name_alloc_retire_scan u_scan (
    .ready (head_ready),
    .count (retire_count)
  );

  // Completions mark done first; retire and allocation then touch disjoint entries.
  always_comb begin
    valid_next = valid_reg;
    done_next  = done_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    for (int p = 0; p < numCompletePorts; p++) begin
      if (bus.completeValid_i[p] && valid_reg[bus.completeName_i[p]])
        done_next[bus.completeName_i[p]] = 1'b1;
    end
    if (retire_fire) begin
      for (int j = 0; j < MAX_BUNDLE; j++) begin
        if (3'(j) < retire_count) begin
          valid_next[head_name[j]] = 1'b0;
          done_next[head_name[j]]  = 1'b0;
        end
      end
      head_next = head_reg + (W+1)'(retire_count);
    end
    if (alloc_fire) begin
      for (int j = 0; j < MAX_BUNDLE; j++) begin
        if (j <= int'(bus.numInst_i)) begin
          valid_next[tail_name[j]] = 1'b1;
          done_next[tail_name[j]]  = 1'b0;
        end
      end
      tail_next = tail_reg + req_count;
    end
    if (bus.flush_i) begin
      valid_next = '0;
      done_next  = '0;
      head_next  = '0;
      tail_next  = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      valid_reg       <= '0;
      done_reg        <= '0;
      alloc_valid_reg <= 1'b0;
      clear_reg       <= '0;
      for (int j = 0; j < MAX_BUNDLE; j++) begin
        alloc_name_reg[j] <= '0;
        rob_name_reg[j]   <= '0;
      end
    end else begin
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      valid_reg       <= valid_next;
      done_reg        <= done_next;
      alloc_valid_reg <= alloc_fire;
      clear_reg       <= clear_next;
      for (int j = 0; j < MAX_BUNDLE; j++) begin
        alloc_name_reg[j] <= alloc_name_next[j];
        rob_name_reg[j]   <= rob_name_next[j];
      end
    end
  end

  assign bus.allocValid_o = alloc_valid_reg;
  assign bus.allocName1_o = alloc_name_reg[0];
  assign bus.allocName2_o = alloc_name_reg[1];
  assign bus.allocName3_o = alloc_name_reg[2];
  assign bus.allocName4_o = alloc_name_reg[3];
  assign bus.clearName1_o = clear_reg[0];
  assign bus.clearName2_o = clear_reg[1];
  assign bus.clearName3_o = clear_reg[2];
  assign bus.clearName4_o = clear_reg[3];
  assign bus.ROBName1_o   = rob_name_reg[0];
  assign bus.ROBName2_o   = rob_name_reg[1];
  assign bus.ROBName3_o   = rob_name_reg[2];
  assign bus.ROBName4_o   = rob_name_reg[3];
  assign bus.freeCount_o  = free_count;
endmodule

// File: doc/fx_rob_name_alloc.md
Name: fx_rob_name_alloc

Overview:
- Circular ROB-name allocator and in-order retire tracker for the fixed-point out-of-order path.
- Sits beside the FX register alias table. It hands a ROB entry name to each instruction of a renamed 1-4 wide bundle.
- It records completions and retires up to 4 completed head entries per cycle.
- The retire results drive the RAT's clearName/ROBName inputs.

Parameters:
- ROBEntryWidth, 7, log2 of ROB entries (128 entries).
- numCompletePorts, 2, completion write ports per cycle.

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  gates allocation and retire.
- flush_i  in  1  synchronous pipeline flush.
- allocValid_i  in  1  bundle requests names.
- numInst_i  in  2  bundle size minus one (0 => 1 inst, 3 => 4 inst).
- stall_o  out  1  combinational; allocValid_i && freeCount < numInst_i+1.
- allocValid_o  out  1  registered; names below are valid.
- allocName1_o..allocName4_o  out  ROBEntryWidth  names for bundle slots 1-4.
- completeValid_i[numCompletePorts]  in  1 each  completion strobe.
- completeName_i[numCompletePorts]  in  ROBEntryWidth each  completing entry.
- clearName1_o..clearName4_o  out  1 each  registered retire strobes to the RAT.
- ROBName1_o..ROBName4_o  out  ROBEntryWidth each  retired entry names.
- freeCount_o  out  ROBEntryWidth+1  free entries (0..128).

Behaviour:
- State:
  - head and tail pointers, each ROBEntryWidth+1 bits wide; the MSB is the wrap bit.
  - Per-entry valid bit and done bit.
- Full/empty:
  - Empty when head == tail.
  - Full when the indices are equal and the wrap bits differ.
  - freeCount = 2^ROBEntryWidth - (tail - head), computed modulo 2^(ROBEntryWidth+1).
- Reset (asynchronous, while reset_i == 0):
  - head = tail = 0; all valid and done bits = 0.
  - allocValid_o, clearNameN_o and all name outputs = 0; freeCount_o = 128.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Allocation (edge where enable_i && allocValid_i && !stall_o && !flush_i):
  - n = numInst_i + 1.
  - allocNameK_o = (tail + K - 1) mod 128 for K = 1..n. Unused slots output 0.
  - Outputs are valid the cycle after the request, with allocValid_o = 1.
  - tail += n; valid is set and done is cleared for each allocated entry.
  - There is no partial allocation: a stalled request allocates nothing and allocValid_o = 0.
  - Tail wraps 127 -> 0 and toggles the wrap bit.
- Completion:
  - Recorded regardless of enable_i.
  - Sets done[completeName] only if valid[completeName]; a completion to an invalid entry is ignored.
  - Two ports naming the same entry is legal; the result is done.
- Retire (edge where enable_i && !flush_i):
  - k = count of consecutive entries from head with valid && done, capped at 4.
  - Registered outputs: clearNameJ_o = 1 and ROBNameJ_o = head + J - 1 for J = 1..k; the rest are 0.
  - head += k; valid and done are cleared for retired entries.
- Latency:
  - A completion sampled at edge E can retire at edge E+1.
  - Done bits written at edge E are not visible to the retire scan at edge E.
- Simultaneous allocation and retire:
  - stall_o and freeCount use the pre-retire head.
  - Freed entries become allocatable the following cycle.
- enable_i low:
  - Allocation and retire are suppressed; allocValid_o and clearNameN_o are 0 next cycle.
  - Pointers are held.
- Flush (priority over everything except reset):
  - All valid and done bits are cleared and head = tail = 0.
  - Outputs are zeroed next cycle, and completions that cycle are dropped.
- Name width arithmetic is modulo 2^ROBEntryWidth; pointer arithmetic is modulo 2^(ROBEntryWidth+1).

Decomposition:
- Shared package (ooo_pkg):
  - ROB_ENTRY_WIDTH and ROB_ENTRIES.
  - MAX_BUNDLE = 4.
  - A rob_ptr_t typedef (index plus wrap bit).
- One sub-module, rob_retire_scan:
  - Purely combinational.
  - Takes the valid/done bits of head..head+3 and outputs k (0..4) as a leading-ones count.

Test Plan:
1. Reset, then allocValid_i = 1, numInst_i = 3 -> next cycle allocName1..4_o = 0,1,2,3, allocValid_o = 1, freeCount_o = 124.
2. Complete names 1 and 0 in one cycle (two ports) -> one cycle later clearName1_o = clearName2_o = 1, ROBName1_o = 0, ROBName2_o = 1, and clearName3_o = 0 because entry 2 is not done.
3. Allocate 128 entries, then request 1 -> stall_o = 1, no allocation. Retire 1 entry -> the next request gets name 0 with the wrap bit toggled.
4. Head at 126 with entries 126, 127, 0, 1 done -> a single retire cycle gives ROBName1..4_o = 126, 127, 0, 1.
5. Complete name 5 while entry 5 is invalid -> no done bit set, and no clear ever issued for 5.
6. Assert flush_i with 10 live entries, then drive reset_i = 0 mid-cycle -> after the flush freeCount_o = 128 and the outputs are 0. The reset clears outputs immediately without waiting for a clock.
